// File: rtl/frame_sequencer_if.sv
// Handshake bundle between the frame sequencer and its sub-units / game FSM.
// The sequencer uses the master modport; the surrounding datapath uses slave.
interface frame_sequencer_if #(
    parameter int unsigned CNT_W = 12
);
    logic             frame_tick;
    logic             run;
    logic             erase_done;
    logic             draw_done;
    logic             hit;
    logic             erase_start;
    logic             update_en;
    logic             draw_start;
    logic             draw_sel;
    logic             busy;
    logic             collided;
    logic             reached_screen_end;
    logic             overrun;
    logic [CNT_W-1:0] frame_count;

    modport master (
        input  frame_tick, run, erase_done, draw_done, hit,
        output erase_start, update_en, draw_start, draw_sel, busy,
               collided, reached_screen_end, overrun, frame_count
    );

    modport slave (
        output frame_tick, run, erase_done, draw_done, hit,
        input  erase_start, update_en, draw_start, draw_sel, busy,
               collided, reached_screen_end, overrun, frame_count
    );
endinterface

// File: rtl/frame_sequencer.sv
// Per-frame scheduler: erase, update, collision check, player draw, obstacle draw.
// Tracks sticky round-lost/won/overrun flags and the per-round frame count.
module frame_sequencer #(
    parameter int unsigned END_FRAMES = 1800,
    parameter int unsigned CNT_W      = 12
) (
    input logic               clock,
    input logic               reset,
    frame_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ERASE  = 3'd1,
        UPDATE = 3'd2,
        CHECK  = 3'd3,
        DRAW_P = 3'd4,
        DRAW_O = 3'd5
    } state_t;

    localparam logic [CNT_W:0] END_VAL = (CNT_W+1)'(END_FRAMES);

    state_t         state;
    logic [CNT_W:0] count_inc;

    assign count_inc = {1'b0, bus.frame_count} + (CNT_W+1)'(1);

    // Start pulses double as "first cycle" markers, so done inputs are ignored
    // on the first cycle of each wait state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                  <= IDLE;
            bus.erase_start        <= 1'b0;
            bus.update_en          <= 1'b0;
            bus.draw_start         <= 1'b0;
            bus.draw_sel           <= 1'b0;
            bus.busy               <= 1'b0;
            bus.collided           <= 1'b0;
            bus.reached_screen_end <= 1'b0;
            bus.overrun            <= 1'b0;
            bus.frame_count        <= '0;
        end else begin
            bus.erase_start <= 1'b0;
            bus.update_en   <= 1'b0;
            bus.draw_start  <= 1'b0;

            // A tick while busy is dropped, never queued.
            if (bus.frame_tick && bus.busy) begin
                bus.overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (!bus.run) begin
                        bus.collided           <= 1'b0;
                        bus.reached_screen_end <= 1'b0;
                        bus.overrun            <= 1'b0;
                        bus.frame_count        <= '0;
                    end else if (bus.frame_tick && !bus.collided && !bus.reached_screen_end) begin
                        state           <= ERASE;
                        bus.erase_start <= 1'b1;
                        bus.busy        <= 1'b1;
                    end
                end
                ERASE: begin
                    if (!bus.erase_start && bus.erase_done) begin
                        state         <= UPDATE;
                        bus.update_en <= 1'b1;
                    end
                end
                UPDATE: begin
                    state <= CHECK;
                end
                CHECK: begin
                    if (bus.hit) begin
                        bus.collided <= 1'b1;
                    end else if (count_inc == END_VAL) begin
                        bus.reached_screen_end <= 1'b1;
                    end
                    if (!(&bus.frame_count)) begin
                        bus.frame_count <= count_inc[CNT_W-1:0];
                    end
                    state          <= DRAW_P;
                    bus.draw_start <= 1'b1;
                    bus.draw_sel   <= 1'b0;
                end
                DRAW_P: begin
                    if (!bus.draw_start && bus.draw_done) begin
                        state          <= DRAW_O;
                        bus.draw_start <= 1'b1;
                        bus.draw_sel   <= 1'b1;
                    end
                end
                DRAW_O: begin
                    if (!bus.draw_start && bus.draw_done) begin
                        state        <= IDLE;
                        bus.draw_sel <= 1'b0;
                        bus.busy     <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.draw_sel <= 1'b0;
                    bus.busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Per-frame scheduler for the game datapath. On each accepted frame tick while a round is in progress, it runs a fixed sequence: erase, position update, collision check, player draw, obstacle draw. Each sub-unit gets a start pulse, and the sequencer waits for its done handshake before moving on. It produces the `collided` and `reached_screen_end` flags consumed by the game state machine, and counts frames played in the current round.

## Interface
- `END_FRAMES`, 1800: frame count at which the round is won.
- `CNT_W`, 12: width of `frame_count`; must satisfy 2^CNT_W > END_FRAMES.
- `clock` in 1: system clock; all logic rises on posedge.
- `reset` in 1: asynchronous, active-high; one clock; forces IDLE and clears every register.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `run` in 1: high while the game state machine is in its play state.
- `erase_done` in 1: eraser finished; sampled only in ERASE after its first cycle.
- `draw_done` in 1: sprite drawer finished; sampled only in DRAW_P/DRAW_O after their first cycle.
- `hit` in 1: collision comparator result; sampled only in CHECK.
- `erase_start` out 1: one-cycle start pulse to the eraser.
- `update_en` out 1: one-cycle enable to the position registers.
- `draw_start` out 1: one-cycle start pulse to the sprite drawer.
- `draw_sel` out 1: 0 = player sprite, 1 = obstacle sprite.
- `busy` out 1: high in every state except IDLE.
- `collided` out 1: sticky round-lost flag.
- `reached_screen_end` out 1: sticky round-won flag.
- `overrun` out 1: sticky flag; a tick was dropped because a frame was still in progress.
- `frame_count` out CNT_W: frames completed this round.

## Operation
**States:** IDLE, ERASE, UPDATE, CHECK, DRAW_P, DRAW_O. All outputs are registered.

**IDLE**
- If `run`=0: clear `collided`, `reached_screen_end`, `overrun` and `frame_count`; ignore ticks.
- If `run`=1 and `frame_tick`=1 and neither sticky flag is set: go to ERASE.
- Otherwise stay in IDLE.

**ERASE**
- `erase_start`=1 on the first cycle only.
- Wait for `erase_done`=1, sampled only from the second ERASE cycle onward, then go to UPDATE.

**UPDATE**
- Lasts exactly one cycle with `update_en`=1, then go to CHECK.

**CHECK**
- Lasts exactly one cycle.
- If `hit`=1, set `collided`.
- Otherwise, if `frame_count`+1 == END_FRAMES, set `reached_screen_end`.
- `frame_count` increments by 1 regardless. It saturates at 2^CNT_W−1 and never wraps.
- If `hit` and the end condition occur in the same CHECK, `collided` wins and `reached_screen_end` stays 0.
- Then go to DRAW_P.

**DRAW_P and DRAW_O**
- `draw_start`=1 on the first cycle only.
- `draw_sel` is held for the whole state: 0 in DRAW_P, 1 in DRAW_O, 0 in all other states.
- Wait for `draw_done` (not sampled on the first cycle).
- DRAW_P goes to DRAW_O; DRAW_O goes to IDLE.

**Boundary conditions**
- **Frame after a flag is set:** the frame that set a sticky flag is still fully drawn. No further frames start until `run` drops and the flags clear.
- **Overrun:** a `frame_tick` while `busy`=1 is dropped and sets `overrun`. It is never queued.
- **`run` falling mid-frame:** the current sequence completes so no handshake is abandoned. Clearing happens on the first IDLE cycle with `run`=0.
- **Done inputs outside their sampling window:** a `done` held high across states does not skip a state, because the first cycle of each wait state is never sampled.
- **Reset mid-operation:** immediate return to IDLE. Any in-flight start pulse is cut, and sub-units are expected to be reset by the same `reset`.

## Timing
- **Reset values:** every output is 0, `frame_count`=0, state IDLE.
- **Minimum frame timing:** tick in IDLE at cycle 0, then
  - cycle 1: ERASE, `erase_start`=1;
  - cycle 2: `erase_done` sampled, earliest accept;
  - cycle 3: UPDATE, `update_en`=1;
  - cycle 4: CHECK;
  - cycle 5: DRAW_P, `draw_start`=1, `draw_sel`=0;
  - cycle 7: DRAW_O, `draw_start`=1, `draw_sel`=1;
  - cycle 9: IDLE, `busy`=0.
- Minimum tick-to-idle is therefore 9 cycles. Each extra wait cycle on a done input adds one cycle.
- **Flag and count visibility:** `collided`, `reached_screen_end` and the new `frame_count` are visible from the first DRAW_P cycle, 5 cycles after the tick at minimum.
- **`overrun` visibility:** visible the cycle after the dropped tick.
- **Start pulses:** `erase_start`, `update_en` and `draw_start` are each exactly one cycle wide and never overlap.

## Test plan
- **Reset:** assert `reset` asynchronously mid-DRAW_P → all outputs 0 before the next edge; state IDLE; no `draw_start` afterwards.
- **Single frame, minimum handshakes:** `run`=1, one tick, `erase_done`/`draw_done` returned one cycle after each start → pulses at cycles 1/3/5/7 relative to the tick, `busy` falls at cycle 9, `frame_count`=1.
- **Collision wins over end:** set END_FRAMES=4 and play frames with `hit`=1 in frame 4 → `collided`=1, `reached_screen_end`=0. Further ticks produce no `erase_start`. `run`=0 then clears the flags and count.
- **Win at END_FRAMES:** END_FRAMES=4, `hit`=0, four frames → `reached_screen_end`=1 at the DRAW_P of frame 4, `frame_count`=4, a fifth tick is ignored.
- **Overrun and stuck-high done:** tick during ERASE with `erase_done` delayed 20 cycles → `overrun`=1, only one `erase_start`. Then hold `draw_done`=1 constantly → each DRAW state lasts exactly 2 cycles.
- **`run` drop mid-frame:** drop `run` in UPDATE → the sequence completes through DRAW_O, then IDLE clears `frame_count` to 0.
